// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM, long-press hold counter.
// Latency: KEY_OK / Press_Pulse / Release_Pulse change DEBOUNCE_T+3 edges after a new stable pin level is first sampled.
// Backpressure: none; pulse outputs are single-cycle and must be consumed when they occur.
module key_debouncer #(
  parameter logic [29:0] DEBOUNCE_T     = 30'd1_000_000,
  parameter logic [29:0] LONG_T         = 30'd100_000_000,
  parameter logic        KEY_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic KEY_In,
  output logic KEY_OK,
  output logic Press_Pulse,
  output logic Release_Pulse,
  output logic Long_Press
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // The released pin level equals KEY_ACTIVE_LOW, so the synchronizer resets to it.
  localparam logic PIN_IDLE = KEY_ACTIVE_LOW;

  logic        sync1_q, sync2_q;
  logic        key_s;
  state_e      state_q, state_d;
  logic [29:0] db_cnt_q, db_cnt_d;
  logic [29:0] hold_cnt_q, hold_cnt_d;
  logic        key_ok_q, key_ok_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;

  // Bring the asynchronous pin into the CLK domain.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= KEY_In;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity: key_s = 1 means the key is pressed.
  assign key_s = sync2_q ^ KEY_ACTIVE_LOW;

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= RELEASED;
      db_cnt_q   <= 30'd0;
      hold_cnt_q <= 30'd0;
      key_ok_q   <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      key_ok_q   <= key_ok_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  // Next-state logic: debounce transitions, hold counting and one-cycle pulses.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    key_ok_d   = key_ok_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    // Hold time runs while the press is accepted, including a pending release.
    // Parking the counter at LONG_T (one past the firing value) means it never
    // fires twice and never wraps.
    if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      if (hold_cnt_q == LONG_T - 30'd1) begin
        long_d     = 1'b1;
        hold_cnt_d = LONG_T;
      end else if (hold_cnt_q < LONG_T) begin
        hold_cnt_d = hold_cnt_q + 30'd1;
      end
    end

    case (state_q)
      RELEASED: begin
        if (key_s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = 30'd0;
        end
      end
      PRESS_WAIT: begin
        // A bounce back wins over a counter that has just expired.
        if (!key_s) begin
          state_d  = RELEASED;
          db_cnt_d = 30'd0;
        end else if (db_cnt_q == DEBOUNCE_T - 30'd1) begin
          state_d    = PRESSED;
          press_d    = 1'b1;
          key_ok_d   = 1'b1;
          hold_cnt_d = 30'd0;
        end else begin
          db_cnt_d = db_cnt_q + 30'd1;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = 30'd0;
        end
      end
      RELEASE_WAIT: begin
        // Return to PRESSED silently; hold_cnt keeps its running value.
        if (key_s) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DEBOUNCE_T - 30'd1) begin
          state_d    = RELEASED;
          release_d  = 1'b1;
          key_ok_d   = 1'b0;
          hold_cnt_d = 30'd0;
        end else begin
          db_cnt_d = db_cnt_q + 30'd1;
        end
      end
      default: begin
        state_d  = RELEASED;
        db_cnt_d = 30'd0;
      end
    endcase
  end

  assign KEY_OK        = key_ok_q;
  assign Press_Pulse   = press_q;
  assign Release_Pulse = release_q;
  assign Long_Press    = long_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (DEBOUNCE_T=8, LONG_T=40, active-low pin).
// Reference model: run-length of disagreement between the delayed key and the accepted level.
// Directed steps followed by randomized pin runs, all checked every cycle.
module tb_key_debouncer;
  localparam int DEB_T = 8;
  localparam int LNG_T = 40;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic KEY_In = 1'b0;
  logic KEY_OK, Press_Pulse, Release_Pulse, Long_Press;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic pin_q[$];   // pin values as seen by the key logic, two edges late
  logic acc;        // accepted level, 1 = pressed
  int   run;        // consecutive samples disagreeing with acc
  int   since;      // edges since press acceptance
  logic exp_press, exp_rel, exp_long;

  // Observation bookkeeping
  int edge_n, n_press, n_rel, n_long, press_edge, rel_edge, long_edge;
  int p0, r0, l0;

  key_debouncer #(
    .DEBOUNCE_T(30'd8),
    .LONG_T(30'd40),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .KEY_In(KEY_In),
    .KEY_OK(KEY_OK),
    .Press_Pulse(Press_Pulse),
    .Release_Pulse(Release_Pulse),
    .Long_Press(Long_Press)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    pin_q.delete();
    pin_q.push_back(1'b1);
    pin_q.push_back(1'b1);
    acc       = 1'b0;
    run       = 0;
    since     = 0;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    exp_long  = 1'b0;
  endfunction

  // One rising edge: a level change is accepted once DEB_T+1 consecutive
  // delayed samples disagree with the accepted level.
  function automatic void model_step(input logic p);
    logic ks;
    ks = ~pin_q.pop_front();
    pin_q.push_back(p);
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    exp_long  = 1'b0;
    if (acc) begin
      since++;
      if (since == LNG_T) exp_long = 1'b1;
    end
    if (ks != acc) begin
      run++;
      if (run == DEB_T + 1) begin
        acc = ks;
        run = 0;
        if (acc) begin
          exp_press = 1'b1;
          since     = 0;
        end else begin
          exp_rel = 1'b1;
        end
      end
    end else begin
      run = 0;
    end
  endfunction

  // Drive the pin for one cycle (called at a falling edge), check at the next falling edge.
  task automatic cyc(input logic p);
    KEY_In = p;
    @(posedge CLK);
    model_step(p);
    edge_n++;
    @(negedge CLK);
    chk1("key_ok", KEY_OK, acc);
    chk1("press_pulse", Press_Pulse, exp_press);
    chk1("release_pulse", Release_Pulse, exp_rel);
    chk1("long_press", Long_Press, exp_long);
    chk1("press_release_exclusive", Press_Pulse & Release_Pulse, 1'b0);
    if (Press_Pulse === 1'b1) begin n_press++; press_edge = edge_n; end
    if (Release_Pulse === 1'b1) begin n_rel++; rel_edge = edge_n; end
    if (Long_Press === 1'b1) begin n_long++; long_edge = edge_n; end
  endtask

  task automatic run_pin(input logic p, input int n);
    for (int i = 0; i < n; i++) cyc(p);
  endtask

  initial begin
    logic v;
    int   len;
    n_press = 0; n_rel = 0; n_long = 0;
    press_edge = 0; rel_edge = 0; long_edge = 0; edge_n = 0;
    model_reset();

    // Reset state with the pin already pressed
    KEY_In = 1'b0;
    RSTn   = 1'b0;
    #3;
    chk1("rst_key_ok", KEY_OK, 1'b0);
    chk1("rst_press", Press_Pulse, 1'b0);
    chk1("rst_release", Release_Pulse, 1'b0);
    chk1("rst_long", Long_Press, 1'b0);
    @(negedge CLK);
    RSTn   = 1'b1;
    edge_n = 0;
    run_pin(1'b0, 14);
    chkn("post_reset_press_edge", press_edge, 11);
    chkn("post_reset_press_count", n_press, 1);

    // Release, then clean press
    run_pin(1'b1, 20);
    p0 = n_press; r0 = n_rel; l0 = n_long;
    edge_n = 0;
    run_pin(1'b0, 14);
    chkn("clean_press_edge", press_edge, 11);
    chkn("clean_press_count", n_press - p0, 1);
    chkn("clean_press_no_release", n_rel - r0, 0);
    chk1("clean_press_key_ok", KEY_OK, 1'b1);

    // Long press: keep holding well past LONG_T
    run_pin(1'b0, 60);
    chkn("long_edge", long_edge, 11 + LNG_T);
    chkn("long_count", n_long - l0, 1);
    chk1("long_key_ok", KEY_OK, 1'b1);

    // Asynchronous reset in mid-cycle while pressed
    #2;
    RSTn = 1'b0;
    #1;
    model_reset();
    chk1("midrst_key_ok", KEY_OK, 1'b0);
    chk1("midrst_press", Press_Pulse, 1'b0);
    chk1("midrst_release", Release_Pulse, 1'b0);
    chk1("midrst_long", Long_Press, 1'b0);
    @(negedge CLK);
    RSTn = 1'b1;
    p0 = n_press;
    edge_n = 0;
    run_pin(1'b0, 14);
    chkn("refresh_press_edge", press_edge, 11);
    chkn("refresh_press_count", n_press - p0, 1);

    // Release with bounce
    p0 = n_press; r0 = n_rel;
    run_pin(1'b1, 3);
    run_pin(1'b0, 2);
    edge_n = 0;
    run_pin(1'b1, 14);
    chkn("bounce_release_edge", rel_edge, 11);
    chkn("bounce_release_count", n_rel - r0, 1);
    chkn("bounce_release_no_press", n_press - p0, 0);
    chk1("bounce_release_key_ok", KEY_OK, 1'b0);

    // Press bounce rejection
    p0 = n_press;
    for (int k = 0; k < 4; k++) begin
      run_pin(1'b0, 5);
      run_pin(1'b1, 2);
    end
    run_pin(1'b1, 15);
    chkn("bounce_press_none", n_press - p0, 0);
    chk1("bounce_press_key_ok", KEY_OK, 1'b0);

    // Boundary: bounce exactly when the count expires, then one cycle longer
    p0 = n_press;
    run_pin(1'b0, DEB_T);
    run_pin(1'b1, 15);
    chkn("edge_bounce_none", n_press - p0, 0);
    edge_n = 0;
    run_pin(1'b0, DEB_T + 1);
    run_pin(1'b1, 3);
    chkn("edge_accept_edge", press_edge, 11);
    chkn("edge_accept_count", n_press - p0, 1);
    run_pin(1'b1, 15);

    // Short press followed by a second press
    p0 = n_press; r0 = n_rel; l0 = n_long;
    run_pin(1'b0, 31);
    run_pin(1'b1, 15);
    chkn("short_press_count", n_press - p0, 1);
    chkn("short_release_count", n_rel - r0, 1);
    chkn("short_no_long", n_long - l0, 0);
    p0 = n_press;
    run_pin(1'b0, 14);
    chkn("second_press_count", n_press - p0, 1);
    run_pin(1'b1, 15);

    // Randomized pin runs against the model
    for (int k = 0; k < 60; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(40, 60))
                                        : int'($urandom_range(1, 14));
      run_pin(v, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
